// File: rtl/sd_cmd_seq.sv
// SD-card SPI-mode command sequencer: frames a 6-byte command, polls for R1
// with a bounded retry count, sends one gap byte, and owns chip select.
module sd_cmd_seq #(
  parameter int unsigned POLL_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic [7:0]  spi_tx,
  output logic        spi_start,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        sd_cs_n
);

  typedef enum logic [3:0] {
    IDLE, SETUP, SEND, WAIT_TX, POLL, WAIT_POLL, GAP, WAIT_GAP, FIN
  } state_t;

  state_t      state, next;
  logic [47:0] frame;
  logic [2:0]  k;
  logic [7:0]  poll_cnt;
  logic        poll_last;

  assign poll_last = (poll_cnt == 8'(POLL_MAX));

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (cmd_start) next = SETUP;
      // SETUP also launches byte 0 so the first strobe lands two cycles after cmd_start.
      SETUP:     next = WAIT_TX;
      SEND:      next = WAIT_TX;
      WAIT_TX:   if (spi_done) next = (k == 3'd5) ? POLL : SEND;
      POLL:      next = WAIT_POLL;
      WAIT_POLL: if (spi_done) next = (!spi_rx[7] || poll_last) ? GAP : POLL;
      GAP:       next = WAIT_GAP;
      WAIT_GAP:  if (spi_done) next = FIN;
      FIN:       next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '1;
      timeout   <= 1'b0;
      spi_tx    <= '1;
      spi_start <= 1'b0;
      sd_cs_n   <= 1'b1;
      frame     <= '1;
      k         <= '0;
      poll_cnt  <= '0;
    end else begin
      state     <= next;
      spi_start <= (state == SETUP) || (state == SEND) || (state == POLL) || (state == GAP);
      done      <= (next == FIN);
      busy      <= (next != IDLE) && (next != FIN);
      sd_cs_n   <= (next == IDLE) || (next == FIN);
      unique case (state)
        IDLE: begin
          if (cmd_start) begin
            frame   <= {2'b01, cmd_idx, cmd_arg, cmd_crc, 1'b1};
            resp    <= '1;
            timeout <= 1'b0;
            k       <= '0;
          end
        end
        SETUP, SEND: spi_tx <= frame[47:40];
        WAIT_TX: begin
          if (spi_done) begin
            frame    <= {frame[39:0], 8'hFF};
            k        <= k + 3'd1;
            poll_cnt <= '0;
          end
        end
        POLL: begin
          spi_tx   <= '1;
          poll_cnt <= poll_cnt + 8'd1;
        end
        WAIT_POLL: begin
          if (spi_done) begin
            if (!spi_rx[7]) begin
              resp <= spi_rx;
            end else if (poll_last) begin
              timeout <= 1'b1;
              resp    <= '1;
            end
          end
        end
        GAP:     spi_tx <= '1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Randomized bench for sd_cmd_seq: byte-engine model plus a transaction-level
// reference model of framing, polling, timeout and strobe latency.
module tb_sd_cmd_seq;
  localparam int unsigned POLL_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy, done, timeout, spi_start, spi_done, sd_cs_n;
  logic [7:0]  resp, spi_tx, spi_rx;

  sd_cmd_seq #(.POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_idx(cmd_idx),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .busy(busy), .done(done),
    .resp(resp), .timeout(timeout), .spi_tx(spi_tx), .spi_start(spi_start),
    .spi_done(spi_done), .spi_rx(spi_rx), .sd_cs_n(sd_cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  logic [7:0] rx_q[$];
  int         exp_polls;
  logic [7:0] exp_resp;
  logic       exp_to;
  int         start_cyc, last_sd_cyc, eng_n, sd_cnt, done_cnt, cs_viol;
  bit         in_txn, stray_req;

  // Byte-engine model and monitors.
  initial begin : engine
    bit engine_busy;
    int countdown, cur_idx;
    engine_busy = 0;
    spi_done    = 1'b0;
    spi_rx      = 8'hFF;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst) begin
        engine_busy = 0;
        continue;
      end
      if (done) begin
        done_cnt++;
        in_txn = 0;
        check("done_latency", cyc - last_sd_cyc, 1);
        check("cs_n_at_done", sd_cs_n, 1'b1);
        check("busy_at_done", busy, 1'b0);
      end
      if (in_txn && cyc > start_cyc && sd_cs_n) cs_viol++;
      if (spi_start) begin
        check("strobe_overlap", engine_busy, 1'b0);
        if (eng_n == 0) check("first_strobe_latency", cyc - start_cyc, 2);
        else            check("strobe_latency", cyc - last_sd_cyc, 2);
        got_tx.push_back(spi_tx);
      end
      if (stray_req) begin
        spi_done  = 1'b1;
        spi_rx    = 8'($urandom);
        stray_req = 0;
      end else if (engine_busy) begin
        countdown--;
        if (countdown == 0) begin
          engine_busy = 0;
          spi_done    = 1'b1;
          if (cur_idx >= 6 && cur_idx < 6 + exp_polls)
            spi_rx = (cur_idx - 6 < rx_q.size()) ? rx_q[cur_idx - 6] : 8'hFF;
          else
            spi_rx = 8'($urandom);
          last_sd_cyc = cyc;
          sd_cnt++;
        end
      end else if (spi_start) begin
        engine_busy = 1;
        countdown   = $urandom_range(1, 3);
        cur_idx     = eng_n;
      end
      if (spi_start) eng_n++;
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input bit disturb, input bit abort);
    logic [7:0] r;
    bit dist_done;
    int n0;
    exp_tx.delete();
    exp_tx.push_back({2'b01, idx});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(arg >> (8 * i)));
    exp_tx.push_back({crc, 1'b1});
    exp_resp  = 8'hFF;
    exp_to    = 1'b0;
    exp_polls = 0;
    for (int p = 1; p <= int'(POLL_MAX); p++) begin
      r = (p <= rx_q.size()) ? rx_q[p - 1] : 8'hFF;
      exp_tx.push_back(8'hFF);
      exp_polls = p;
      if (!r[7]) begin
        exp_resp = r;
        break;
      end
      if (p == int'(POLL_MAX)) exp_to = 1'b1;
    end
    exp_tx.push_back(8'hFF);

    got_tx.delete();
    eng_n = 0; sd_cnt = 0; done_cnt = 0; cs_viol = 0; dist_done = 0;
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; cmd_start = 1'b1;
    start_cyc = cyc;
    last_sd_cyc = cyc;
    in_txn = 1;
    for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
      @(negedge clk);
      if (disturb && !dist_done && got_tx.size() >= 3) begin
        cmd_start = 1'b1;
        cmd_idx   = ~idx;
        cmd_arg   = ~arg;
        cmd_crc   = ~crc;
        dist_done = 1;
      end else begin
        cmd_start = 1'b0;
      end
      if (abort && sd_cnt >= 3) begin
        @(posedge clk);
        #2 rst = 1'b1;
        in_txn = 0;
        #1;
        check("abort_cs_n", sd_cs_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_spi_start", spi_start, 1'b0);
        check("abort_resp", resp, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        stray_req = 1;
        n0 = got_tx.size();
        repeat (10) @(negedge clk);
        check("stray_done_no_strobe", got_tx.size(), n0);
        check("stray_done_busy", busy, 1'b0);
        return;
      end
    end
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("strobe_count", got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      check($sformatf("tx_byte[%0d]", i), (i < got_tx.size()) ? got_tx[i] : 8'hxx, exp_tx[i]);
    check("resp", resp, exp_resp);
    check("timeout", timeout, exp_to);
    check("cs_n_low_in_window", cs_viol, 0);
    check("idle_cs_n", sd_cs_n, 1'b1);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst = 1'b1; cmd_start = 1'b0; cmd_idx = '0; cmd_arg = '0; cmd_crc = '0;
    in_txn = 0; stray_req = 0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_resp", resp, 8'hFF);
    check("rst_timeout", timeout, 1'b0);
    check("rst_spi_tx", spi_tx, 8'hFF);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_cs_n", sd_cs_n, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    rx_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0000_0000, 7'h4A, 0, 0);
    rx_q = '{8'h00};
    run_cmd(6'd17, 32'h1234_5678, 7'h2A, 0, 0);
    rx_q.delete();
    run_cmd(6'd8, 32'h0000_01AA, 7'h43, 0, 0);
    rx_q = '{8'hFF, 8'hFF, 8'h05};
    run_cmd(6'd55, 32'hDEAD_BEEF, 7'h11, 1, 0);
    rx_q = '{8'h01};
    run_cmd(6'd9, 32'hCAFE_0001, 7'h3C, 0, 1);
    rx_q = '{8'hC1, 8'h00};
    run_cmd(6'd16, 32'h0000_0200, 7'h0A, 0, 0);

    for (int i = 0; i < 20; i++) begin
      rx_q.delete();
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++)
        rx_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
      run_cmd(6'($urandom), 32'($urandom), 7'($urandom), ($urandom_range(0, 3) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
